// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction field positions, PC step and the default reset address.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam int          OPCODE_MSB       = 15;
  localparam int          OPCODE_LSB       = 12;
  localparam logic [15:0] PC_STEP          = 16'd2;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Instruction addresses are halfword aligned; bit 0 is always cleared.
  function automatic logic [15:0] align_pc(input logic [15:0] addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// One-entry prefetch buffer (instruction word plus its address) with a
// valid flag and a flush input. Only built when IFETCH_PREFETCH_EN is defined.
`ifdef IFETCH_PREFETCH_EN
module ifetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] wr_data,
  input  logic [15:0] wr_pc,
  output logic        valid,
  output logic [15:0] data,
  output logic [15:0] pc
);

  logic        valid_r;
  logic [15:0] data_r;
  logic [15:0] pc_r;

  // Storage register: flush beats write, write beats read.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= 16'h0000;
      pc_r    <= 16'h0000;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (wr_en) begin
      valid_r <= 1'b1;
      data_r  <= wr_data;
      pc_r    <= wr_pc;
    end else if (rd_en) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign pc    = pc_r;

endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/WAIT/HOLD sequencer with a single outstanding
// memory request, branch redirect with response squashing, and a held
// instruction presented to decode under a valid/ready handshake.
// Optional prefetching of pc+2 into a one-entry buffer is selected by the
// macro IFETCH_PREFETCH_EN (default build: no prefetch).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [3:0]  opcode,
  output logic [15:0] inst_pc
);

  fetch_state_e state_r, state_s;
  logic [15:0]  pc_r, pc_s;
  logic [15:0]  inst_r, inst_s;
  logic [15:0]  inst_pc_r, inst_pc_s;
  logic         inst_valid_r, inst_valid_s;
  logic         squash_r, squash_s;   // in WAIT: the pending response belongs to a redirected path

`ifdef IFETCH_PREFETCH_EN
  logic         pf_issue_r, pf_issue_s;  // prefetch request goes out this cycle
  logic         pf_pend_r, pf_pend_s;    // prefetch response still owed by memory
  logic         pf_rsp_s;
  logic         buf_wr_s, buf_rd_s, buf_flush_s;
  logic         buf_valid_s;
  logic [15:0]  buf_data_s, buf_pc_s;
  logic [15:0]  pc_next_s;

  assign pc_next_s = pc_r + PC_STEP;
  assign pf_rsp_s  = imem_rvalid && pf_pend_r && !pf_issue_r;

  ifetch_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .flush   (buf_flush_s),
    .wr_en   (buf_wr_s),
    .rd_en   (buf_rd_s),
    .wr_data (imem_rdata),
    .wr_pc   (pc_next_s),
    .valid   (buf_valid_s),
    .data    (buf_data_s),
    .pc      (buf_pc_s)
  );

  assign imem_req  = ((state_r == ST_FETCH) || pf_issue_r) && !reset;
  assign imem_addr = pf_issue_r ? pc_next_s : pc_r;
`else
  assign imem_req  = (state_r == ST_FETCH) && !reset;
  assign imem_addr = pc_r;
`endif

  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign opcode     = inst_r[OPCODE_MSB:OPCODE_LSB];
  assign inst_pc    = inst_pc_r;

  // Next-state and next-register computation; branch redirect has priority.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = inst_valid_r;
    squash_s     = squash_r;
`ifdef IFETCH_PREFETCH_EN
    pf_issue_s   = 1'b0;
    pf_pend_s    = pf_pend_r;
    buf_wr_s     = 1'b0;
    buf_rd_s     = 1'b0;
    buf_flush_s  = 1'b0;
`endif
    case (state_r)
      ST_FETCH: begin
        // The request leaves this cycle regardless; a redirect here must
        // therefore wait out its response as a squashed one.
        state_s = ST_WAIT;
        if (branch_taken) begin
          pc_s     = align_pc(branch_target);
          squash_s = 1'b1;
        end else begin
          squash_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (branch_taken || squash_r) begin
            squash_s = 1'b0;
            state_s  = ST_FETCH;
            if (branch_taken) begin
              pc_s = align_pc(branch_target);
            end else begin
              pc_s = pc_r;
            end
          end else begin
            inst_s       = imem_rdata;
            inst_pc_s    = pc_r;
            inst_valid_s = 1'b1;
            state_s      = ST_HOLD;
`ifdef IFETCH_PREFETCH_EN
            pf_issue_s   = 1'b1;
            pf_pend_s    = 1'b1;
`endif
          end
        end else if (branch_taken) begin
          pc_s     = align_pc(branch_target);
          squash_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
`ifdef IFETCH_PREFETCH_EN
        if (branch_taken) begin
          pc_s         = align_pc(branch_target);
          inst_valid_s = 1'b0;
          buf_flush_s  = 1'b1;
          pf_pend_s    = 1'b0;
          if (pf_pend_r && !pf_rsp_s) begin
            squash_s = 1'b1;
            state_s  = ST_WAIT;
          end else begin
            state_s = ST_FETCH;
          end
        end else if (inst_valid_r && inst_ready) begin
          pc_s = pc_next_s;
          if (buf_valid_s) begin
            inst_s     = buf_data_s;
            inst_pc_s  = buf_pc_s;
            buf_rd_s   = 1'b1;
            pf_issue_s = 1'b1;
            pf_pend_s  = 1'b1;
          end else if (pf_rsp_s) begin
            inst_s     = imem_rdata;
            inst_pc_s  = pc_next_s;
            pf_issue_s = 1'b1;
            pf_pend_s  = 1'b1;
          end else if (pf_pend_r) begin
            // Prefetch of the next word is already in flight: just wait for it.
            inst_valid_s = 1'b0;
            pf_pend_s    = 1'b0;
            state_s      = ST_WAIT;
          end else begin
            inst_valid_s = 1'b0;
            state_s      = ST_FETCH;
          end
        end else if (pf_rsp_s) begin
          buf_wr_s  = 1'b1;
          pf_pend_s = 1'b0;
        end else begin
          state_s = ST_HOLD;
        end
`else
        if (branch_taken) begin
          pc_s         = align_pc(branch_target);
          inst_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else if (inst_valid_r && inst_ready) begin
          pc_s         = pc_r + PC_STEP;
          inst_valid_s = 1'b0;
          state_s      = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
`endif
      end
      default: begin
        state_s      = ST_FETCH;
        inst_valid_s = 1'b0;
        squash_s     = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_FETCH;
      pc_r         <= align_pc(RESET_PC);
      inst_r       <= 16'h0000;
      inst_pc_r    <= 16'h0000;
      inst_valid_r <= 1'b0;
      squash_r     <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
      pf_issue_r   <= 1'b0;
      pf_pend_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
      squash_r     <= squash_s;
`ifdef IFETCH_PREFETCH_EN
      pf_issue_r   <= pf_issue_s;
      pf_pend_r    <= pf_pend_s;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch (default build, no prefetch).
// A memory responder with configurable latency and a transaction-level
// reference model run in lock-step; outputs are sampled at the falling edge.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [3:0]  opcode;
  logic [15:0] inst_pc;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .opcode        (opcode),
    .inst_pc       (inst_pc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // memory environment
  logic [15:0] mem [0:255];
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [15:0] mem_addr_q = 16'h0000;
  int          lat = 1;
  bit          rand_lat = 1'b0;
  logic [15:0] addr_log [$];

  // reference model: what the fetch unit owes the outside world
  logic        m_need   = 1'b0;   // a request is due this cycle
  logic        m_out    = 1'b0;   // a request is in flight
  logic        m_squash = 1'b0;   // in-flight response is to be discarded
  logic        m_valid  = 1'b0;
  logic [15:0] m_pc     = 16'h0000;
  logic [15:0] m_inst   = 16'h0000;
  logic [15:0] m_ipc    = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return mem[a[8:1]];
  endfunction

  function automatic logic [15:0] log_at(input int k);
    if (addr_log.size() > k) return addr_log[k];
    else return 16'hxxxx;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic br, input logic [15:0] tgt, input logic rdy,
                            input logic rst, input logic rv, input logic [15:0] rd);
    logic issued, was_out;
    if (rst) begin
      m_need = 1'b1; m_out = 1'b0; m_squash = 1'b0; m_valid = 1'b0;
      m_pc = 16'h0000; m_inst = 16'h0000; m_ipc = 16'h0000;
    end else begin
      issued  = m_need;
      was_out = m_out;
      if (issued) begin
        m_out  = 1'b1;
        m_need = 1'b0;
      end
      if (br) begin
        m_pc    = tgt & 16'hFFFE;
        m_valid = 1'b0;
        if (issued) m_squash = 1'b1;
        else if (was_out && rv) begin
          m_out = 1'b0; m_squash = 1'b0; m_need = 1'b1;
        end else if (was_out) m_squash = 1'b1;
        else m_need = 1'b1;
      end else if (was_out && rv) begin
        m_out = 1'b0;
        if (m_squash) begin
          m_squash = 1'b0; m_need = 1'b1;
        end else begin
          m_inst = rd; m_ipc = m_pc; m_valid = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_pc    = m_pc + 16'd2;
        m_valid = 1'b0;
        m_need  = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs, let memory see the request.
  task automatic tick(input logic br, input logic [15:0] tgt, input logic rdy,
                      input logic rst, input bit do_chk);
    logic        rv;
    logic [15:0] rd;
    @(negedge clk);
    rv = 1'b0;
    rd = 16'($urandom);
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv = 1'b1;
        rd = mem_word(mem_addr_q);
        mem_pend = 1'b0;
      end
    end
    imem_rvalid   = rv;
    imem_rdata    = rd;
    branch_taken  = br;
    branch_target = tgt;
    inst_ready    = rdy;
    reset         = rst;
    #1;
    if (do_chk) begin
      chk("imem_req", {15'd0, imem_req}, {15'd0, m_need & ~rst});
      if (m_need && !rst) chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", {15'd0, inst_valid}, {15'd0, m_valid});
      chk("inst", inst, m_inst);
      chk("opcode", {12'd0, opcode}, {12'd0, m_inst[15:12]});
      chk("inst_pc", inst_pc, m_ipc);
    end
    if (imem_req === 1'b1) begin
      if (do_chk) chk("one_outstanding", {15'd0, mem_pend}, 16'd0);
      mem_pend   = 1'b1;
      mem_cnt    = rand_lat ? int'($urandom_range(1, 4)) : lat;
      mem_addr_q = imem_addr;
      addr_log.push_back(imem_addr);
    end
    model_step(br, tgt, rdy, rst, rv, rd);
  endtask

  task automatic do_reset();
    repeat (5) tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
  endtask

  // Time limit guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed steps followed by randomized traffic.
  initial begin
    bit saw_valid;
    reset = 1'b1; branch_taken = 1'b0; branch_target = 16'h0000;
    inst_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h9123;

    tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (4) tick(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // latency 1, always ready: sequential addresses
    lat = 1;
    addr_log.delete();
    repeat (10) tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("seq_addr0", log_at(0), 16'h0000);
    chk("seq_addr1", log_at(1), 16'h0002);
    chk("seq_addr2", log_at(2), 16'h0004);

    // decode stalls: instruction held, no new request
    do_reset();
    addr_log.delete();
    repeat (8) tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("stall_valid", {15'd0, inst_valid}, 16'd1);
    chk("stall_inst", inst, 16'h9123);
    chk("stall_opcode", {12'd0, opcode}, 16'h0009);
    chk("stall_inst_pc", inst_pc, 16'h0000);
    chk("stall_req_count", 16'(addr_log.size()), 16'd1);

    // redirect to 0xFFFF (aligned to 0xFFFE), accept, wrap to 0x0000
    lat = 2;
    tick(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12 && !m_valid; i++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    lat = 3;
    tick(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("wrap_inst_pc", inst_pc, 16'hFFFE);
    addr_log.delete();
    for (int i = 0; i < 5 && addr_log.size() == 0; i++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("wrap_addr", log_at(0), 16'h0000);

    // redirect while waiting on a latency-3 response
    addr_log.delete();
    saw_valid = 1'b0;
    tick(1'b1, 16'h0041, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && addr_log.size() == 0; i++) begin
      tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      if (inst_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("squash_addr", log_at(0), 16'h0040);
    chk("squash_no_valid", {15'd0, saw_valid}, 16'd0);

    // branch and handshake in the same HOLD cycle
    for (int i = 0; i < 12 && !m_valid; i++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    addr_log.delete();
    tick(1'b1, 16'h0100, 1'b1, 1'b0, 1'b1);
    chk("brhs_inst_pc", inst_pc, 16'h0040);
    tick(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("brhs_valid_low", {15'd0, inst_valid}, 16'd0);
    chk("brhs_addr", log_at(0), 16'h0100);

    // randomized traffic with random latency, branches, stalls and resets
    rand_lat = 1'b1;
    repeat (600) begin
      if ($urandom_range(0, 99) < 1) do_reset();
      else tick(1'($urandom_range(0, 99) < 8), 16'($urandom), 1'($urandom_range(0, 99) < 60),
                1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
